// File: rtl/uart_pkg.sv
// Shared UART definitions: word width, receive FIFO depth and the receiver's
// state encoding, kept in one place so the receiver and its FIFO agree.
package uart_pkg;

  localparam int UART_DATA_BITS         = 8;
  localparam int UART_RX_FIFO_ADDR_BITS = 4;

  typedef enum logic [1:0] {
    idle  = 2'd0,
    start = 2'd1,
    data  = 2'd2,
    stop  = 2'd3
  } uart_rx_state_t;

  // Depth of a FIFO addressed by addr_bits bits.
  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the receive FIFO: synchronous write, asynchronous
// read, no reset (contents survive reset by design).
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int ADDR_BITS = UART_RX_FIFO_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART receiver, with a sticky
// flag recording any word dropped because the queue was full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int ADDR_BITS = UART_RX_FIFO_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic               rd_accept;
  logic               wr_accept;
  logic               drop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);
  assign drop      = wr_en && full && !rd_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Set takes priority so a drop coinciding with a clear is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (wr_accept),
    .waddr(wr_ptr[ADDR_BITS-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[ADDR_BITS-1:0]),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a reference queue and occupancy model
// predict every popped word and the flags after each clock.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          ovf_clr;

  logic [DW-1:0] sb [$];
  int            mCount;
  logic          mOvf;
  int            checkCount;
  int            passCount;

  uart_rx_fifo #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, ".count"}, 32'(count), 32'(mCount));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(mCount == 0));
    checkOutput({tag, ".full"}, 32'(full), 32'(mCount == DEPTH));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
    logic          rdOk;
    logic          wrOk;
    logic [DW-1:0] exp;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    ovf_clr = clr;
    #1;
    rdOk = re && (mCount > 0);
    wrOk = we && ((mCount < DEPTH) || rdOk);
    if (rdOk) begin
      exp = sb.pop_front();
      checkOutput("rd_data", 32'(rd_data), 32'(exp));
    end
    if (wrOk) sb.push_back(wd);
    if (we && !wrOk) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
    mCount = mCount + int'(wrOk) - int'(rdOk);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    checkFlags("cycle");
  endtask

  task automatic checkHead(input string tag);
    logic [DW-1:0] exp;
    exp = sb[0];
    checkOutput(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic drain();
    while (mCount > 0) applyStimulus(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    mCount     = 0;
    mOvf       = 1'b0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    ovf_clr    = 1'b0;
    wr_data    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkFlags("reset");

    // Three words then three pops.
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
    checkOutput("three.count", 32'(count), 32'd3);
    checkOutput("three.head", 32'(rd_data), 32'h41);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("three.empty", 32'(empty), 32'd1);

    // Fill, then one dropped write.
    fill(8'h00);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("drop.full", 32'(full), 32'd1);
    checkOutput("drop.count", 32'(count), 32'd16);
    checkOutput("drop.overflow", 32'(overflow), 32'd1);
    drain();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr.overflow", 32'(overflow), 32'd0);

    // Full with simultaneous write and pop.
    fill(8'h10);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("fullrw.count", 32'(count), 32'd16);
    checkOutput("fullrw.overflow", 32'(overflow), 32'd0);
    drain();

    // Empty with simultaneous write and pop, then a pop while empty.
    applyStimulus(1'b1, 8'h7E, 1'b1, 1'b0);
    checkOutput("emptyrw.count", 32'(count), 32'd1);
    checkOutput("emptyrw.head", 32'(rd_data), 32'h7E);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("emptypop.count", 32'(count), 32'd0);

    // Overflow clear alone, then drop and clear together.
    fill(8'h60);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("ovfclr.alone", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'hEF, 1'b0, 1'b1);
    checkOutput("ovfclr.setwins", 32'(overflow), 32'd1);
    checkHead("ovfclr.head");
    drain();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Forty words across pointer wrap with random pop gaps.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, DW'(i), (mCount >= 12) || ($urandom_range(0, 1) == 1), 1'b0);
    end
    drain();

    // Asynchronous reset with five words stored.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hC0 + DW'(i), 1'b0, 1'b0);
    checkOutput("prerst.count", 32'(count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    mCount = 0;
    mOvf   = 1'b0;
    checkOutput("rst.empty", 32'(empty), 32'd1);
    checkOutput("rst.count", 32'(count), 32'd0);
    checkOutput("rst.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkHead("postrst.head");
    drain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Each completed frame is written on the receiver's one-cycle `data_ready` pulse, and the block presents a first-word-fall-through read interface to the consuming logic (command parser / display driver). It absorbs bursts while the consumer is busy and flags any bytes lost to overflow.

## Interface

Parameters:
- `DATA_BITS`, 8: width of one received word; must match the receiver.
- `ADDR_BITS`, 4: log2 of FIFO depth (depth = 2**ADDR_BITS = 16); legal range 1–8.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_data`  in  DATA_BITS  received word; connect to the receiver's `data_out`.
- `wr_en`  in  1  write strobe; connect to the receiver's `data_ready` (one-cycle pulse).
- `rd_en`  in  1  pop request from the consumer.
- `rd_data`  out  DATA_BITS  head-of-queue word; valid whenever `empty`=0.
- `empty`  out  1  queue holds zero words.
- `full`  out  1  queue holds 2**ADDR_BITS words.
- `count`  out  ADDR_BITS+1  number of stored words, 0..2**ADDR_BITS.
- `overflow`  out  1  sticky: at least one write was dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow`.

## Operation

- Pointers `wr_ptr` and `rd_ptr` are ADDR_BITS+1 bits wide. The low ADDR_BITS bits address the memory; the MSB is the wrap bit.
  - `empty` = (wr_ptr == rd_ptr).
  - `full` = (MSBs differ, low bits equal).
  - `count` = wr_ptr − rd_ptr, computed modulo 2**(ADDR_BITS+1).
- Write accepted when `wr_en`=1 and (`full`=0, or `rd_en`=1 with `empty`=0):
  - `mem[wr_ptr]` ← `wr_data`;
  - `wr_ptr` increments and wraps naturally.
- Read accepted when `rd_en`=1 and `empty`=0: `rd_ptr` increments. A read while empty is ignored, with no pointer change and no error flag.
- `rd_data` = `mem[rd_ptr[ADDR_BITS-1:0]]`, a combinational read (FWFT). It is don't-care while `empty`=1.
- Overflow:
  - `wr_en`=1 while `full`=1 and no accepted read → the word is dropped and `overflow` is set.
  - `ovf_clr` clears `overflow`.
  - If a drop and `ovf_clr` occur in the same cycle, set wins.
- Simultaneous events:
  - Full with write and read in the same cycle: both proceed, `count` unchanged, no overflow.
  - Empty with write and read in the same cycle: the write is accepted, the read is ignored, and `count` becomes 1.
- Reset (at any time, including mid-burst):
  - `wr_ptr`=`rd_ptr`=0, `overflow`=0;
  - outputs become `empty`=1, `full`=0, `count`=0;
  - memory contents are not reset.

## Timing

- Write latency is 1 cycle. A write at edge N makes `empty`=0 and `rd_data`=written word visible after edge N, i.e. usable in cycle N+1.
- Pop: `rd_en` high at edge N removes the head word. The next word appears on `rd_data` after edge N, or `empty`=1 if none remain.
- `full`, `empty`, `count` and `overflow` are all registered-state derived. They have no combinational path from `wr_en`, `rd_en` or `ovf_clr`.
- `wr_en` is a single-cycle pulse, and each pulse is one word. A multi-cycle `wr_en` writes one word per cycle.
- Sustained throughput: one write and one read per cycle.

## Structure

- Shared package `uart_pkg` holds:
  - `UART_DATA_BITS` (8);
  - `UART_RX_FIFO_ADDR_BITS` (4);
  - the receiver's state encoding constants (`idle`, `start`, `data`, `stop`), so that the receiver and the FIFO share one source.
- One sub-module, `uart_fifo_ram`: a register array of 2**ADDR_BITS × DATA_BITS with a synchronous write port and an asynchronous read port, and no reset.
- Pointer, flag and overflow logic live in `uart_rx_fifo`.

## Test plan

- Reset, then write 0x41, 0x42, 0x43 one cycle apart.
  - → `count`=3, `rd_data`=0x41.
  - Three pops → reads return 0x41, 0x42, 0x43; then `empty`=1 and `count`=0.
- Fill with 0x00..0x0F, then issue one more write of 0xAA.
  - → `full`=1, `count`=16, `overflow`=1.
  - Draining returns 0x00..0x0F; 0xAA is never seen.
- With the queue full, write 0x55 and pop in the same cycle.
  - → `count` stays 16, `overflow` stays 0.
  - The 16th read after that returns 0x55.
- With the queue empty, write 0x7E and `rd_en` in the same cycle → `count`=1, `rd_data`=0x7E. A pop while empty changes nothing.
- Overflow clear:
  - Set `overflow` via a drop. Assert `ovf_clr` with no drop → `overflow`=0 next cycle.
  - Repeat with a drop and `ovf_clr` in the same cycle → `overflow`=1.
- Wrap and reset:
  - Write/read 40 words (0x00..0x27) with random `rd_en` gaps → data order is preserved across pointer wrap.
  - Assert `rst` mid-stream with 5 words stored → immediately `empty`=1, `count`=0, `overflow`=0.
